// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - core request/completion and memory control signals for mem_bus_master
// Ports (master modport, i.e. the initiator's view):
//   req, we, addr_in, wdata  in   core request, sampled only while idle
//   busy, done, rdata        out  progress, completion pulse, last read data
//   mem_addr, READ, WRITE    out  memory address and strobes
// The bidirectional data bus is a plain inout on the initiator, not part of this bundle.
interface mem_bus_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              READ;
  logic              WRITE;

  modport master (
    input  req, we, addr_in, wdata,
    output busy, done, rdata, mem_addr, READ, WRITE
  );

  modport slave (
    output req, we, addr_in, wdata,
    input  busy, done, rdata, mem_addr, READ, WRITE
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - sequenced read/write initiator for the shared-bus data memory
// Ports:
//   clk    in     rising-edge clock
//   rst_n  in     asynchronous active-low reset
//   bus    master core request/completion and memory address/strobes
//   data   inout  shared memory data bus, driven only during a write
// Sequence per operation: IDLE -> SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> TAIL (1) -> IDLE.
// SETUP_CYC and STROBE_CYC must lie in 1..15 to fit the 4-bit counter.
module mem_bus_master #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_master_if.master  bus,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    TAIL   = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              oe_q, oe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      read_q  <= read_d;
      write_q <= write_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = SETUP;
          cnt_d   = SETUP_LAST;
          we_d    = bus.we;
          addr_d  = bus.addr_in;
          wdata_d = bus.wdata;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = TAIL;
          // Memory has had the whole strobe window to drive the bus; sample on the falling strobe edge.
          if (!we_q) rdata_d = data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so every one of them comes straight from a flop.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == TAIL);
    read_d  = (state_d == STROBE) && !we_d;
    write_d = (state_d == STROBE) && we_d;
    // Write data is held through TAIL so the memory sees hold time after WRITE falls.
    oe_d    = busy_d && we_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = addr_q;
  assign bus.READ     = read_q;
  assign bus.WRITE    = write_q;

  assign data = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard bench for mem_bus_master, default and 3/3 timing instances
module tb_mem_bus_master;

  localparam int S1 = 1;
  localparam int T1 = 2;
  localparam int S2 = 3;
  localparam int T2 = 3;
  localparam logic [7:0] KEEP = 8'hC3;

  typedef struct {
    bit         is_wr;
    logic [7:0] wd;
    logic [7:0] rd;
    int         cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  mem_bus_master_if #(.ADDR_W(6), .DATA_W(8)) bus1 ();
  mem_bus_master_if #(.ADDR_W(6), .DATA_W(8)) bus2 ();
  wire [7:0] data1;
  wire [7:0] data2;

  mem_bus_master #(.ADDR_W(6), .DATA_W(8), .SETUP_CYC(S1), .STROBE_CYC(T1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .data  (data1)
  );

  mem_bus_master #(.ADDR_W(6), .DATA_W(8), .SETUP_CYC(S2), .STROBE_CYC(T2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .data  (data2)
  );

  logic [7:0] mem1 [64];
  logic [7:0] mem2 [64];
  bit         mem_init = 1'b0;
  bit         wr_act1  = 1'b0;
  bit         wr_act2  = 1'b0;
  exp_t       sb1 [$];
  exp_t       sb2 [$];
  logic [7:0] rd_model1 = 8'h00;
  logic [7:0] rd_model2 = 8'h00;

  // Memory side: drives the stored word while READ is high, a keeper pattern otherwise,
  // and lets go of the bus for the whole of a write operation.
  assign data1 = wr_act1 ? 8'hzz : (bus1.READ ? mem1[bus1.mem_addr] : KEEP);
  assign data2 = wr_act2 ? 8'hzz : (bus2.READ ? mem2[bus2.mem_addr] : KEEP);

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 8'(i * 5 + 3);
        mem2[i] <= 8'(i * 7 + 1);
      end
      mem1[6'h10] <= 8'h7E;
      mem1[6'h01] <= 8'h99;
      mem1[6'h00] <= 8'h11;
      mem1[6'h3F] <= 8'hE7;
      mem_init    <= 1'b1;
    end else begin
      if (bus1.WRITE) mem1[bus1.mem_addr] <= data1;
      if (bus2.WRITE) mem2[bus2.mem_addr] <= data2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the default-timing instance.
  int         su1 = 0;
  int         st1 = 0;
  logic [5:0] pa1 = '0;
  logic [1:0] ps1 = '0;
  always @(negedge clk) begin
    exp_t e;
    pa1 <= bus1.mem_addr;
    ps1 <= {bus1.READ, bus1.WRITE};
    if (!rst_n) begin
      su1 <= 0;
      st1 <= 0;
    end else begin
      chk("strobe_exclusive_1", 32'(bus1.READ & bus1.WRITE), 0);
      if (bus1.READ) chk("no_drive_during_read_1", 32'(data1), 32'(mem1[bus1.mem_addr]));
      if (bus1.mem_addr != pa1) chk("strobe_steady_on_addr_change_1", 32'({bus1.READ, bus1.WRITE}), 32'(ps1));
      if (!bus1.busy) chk("idle_quiet_1", 32'({bus1.READ, bus1.WRITE, bus1.done}), 0);
      if (bus1.busy && !bus1.done) begin
        if (bus1.READ || bus1.WRITE) st1 <= st1 + 1;
        else su1 <= su1 + 1;
      end
      if (bus1.done) begin
        chk("done_has_request_1", 32'(sb1.size() > 0), 1);
        if (sb1.size() > 0) begin
          e = sb1.pop_front();
          chk("done_cycle_1", 32'(edge_cnt), 32'(e.cnt));
          chk("rdata_1", 32'(bus1.rdata), 32'(e.rd));
          chk("setup_cycles_1", 32'(su1), S1);
          chk("strobe_cycles_1", 32'(st1), T1);
          chk("busy_in_tail_1", 32'(bus1.busy), 1);
          if (e.is_wr) chk("write_hold_1", 32'(data1), 32'(e.wd));
          else chk("read_tail_released_1", 32'(data1), 32'(KEEP));
        end
        su1 <= 0;
        st1 <= 0;
      end
    end
  end

  // Monitor for the 3/3 timing instance.
  int         su2 = 0;
  int         st2 = 0;
  logic [5:0] pa2 = '0;
  logic [1:0] ps2 = '0;
  always @(negedge clk) begin
    exp_t e;
    pa2 <= bus2.mem_addr;
    ps2 <= {bus2.READ, bus2.WRITE};
    if (!rst_n) begin
      su2 <= 0;
      st2 <= 0;
    end else begin
      chk("strobe_exclusive_2", 32'(bus2.READ & bus2.WRITE), 0);
      if (bus2.READ) chk("no_drive_during_read_2", 32'(data2), 32'(mem2[bus2.mem_addr]));
      if (bus2.mem_addr != pa2) chk("strobe_steady_on_addr_change_2", 32'({bus2.READ, bus2.WRITE}), 32'(ps2));
      if (!bus2.busy) chk("idle_quiet_2", 32'({bus2.READ, bus2.WRITE, bus2.done}), 0);
      if (bus2.busy && !bus2.done) begin
        if (bus2.READ || bus2.WRITE) st2 <= st2 + 1;
        else su2 <= su2 + 1;
      end
      if (bus2.done) begin
        chk("done_has_request_2", 32'(sb2.size() > 0), 1);
        if (sb2.size() > 0) begin
          e = sb2.pop_front();
          chk("done_cycle_2", 32'(edge_cnt), 32'(e.cnt));
          chk("rdata_2", 32'(bus2.rdata), 32'(e.rd));
          chk("setup_cycles_2", 32'(su2), S2);
          chk("strobe_cycles_2", 32'(st2), T2);
          if (e.is_wr) chk("write_hold_2", 32'(data2), 32'(e.wd));
          else chk("read_tail_released_2", 32'(data2), 32'(KEEP));
        end
        su2 <= 0;
        st2 <= 0;
      end
    end
  end

  // Drive one request; returns #1 after the accepting edge with the expectation queued.
  task automatic issue(input int d, input bit w, input logic [5:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit hold);
    exp_t e;
    @(negedge clk);
    if (d == 1) begin
      bus1.req = 1'b1; bus1.we = w; bus1.addr_in = a; bus1.wdata = wd; wr_act1 = w;
    end else begin
      bus2.req = 1'b1; bus2.we = w; bus2.addr_in = a; bus2.wdata = wd; wr_act2 = w;
    end
    @(posedge clk);
    #1;
    e.is_wr = w;
    e.wd    = wd;
    if (d == 1) begin
      if (!w) rd_model1 = exp_rd;
      e.rd  = rd_model1;
      e.cnt = edge_cnt + S1 + T1;
      sb1.push_back(e);
      if (!hold) bus1.req = 1'b0;
    end else begin
      if (!w) rd_model2 = exp_rd;
      e.rd  = rd_model2;
      e.cnt = edge_cnt + S2 + T2;
      sb2.push_back(e);
      if (!hold) bus2.req = 1'b0;
    end
  endtask

  task automatic wait_done(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (d == 1) ? bus1.done : bus2.done;
    end
    chk("done_within_budget", 32'(seen), 1);
    @(posedge clk);
    #1;
    if (d == 1) wr_act1 = 1'b0;
    else wr_act2 = 1'b0;
  endtask

  bit         v_w [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [5:0] v_a [5] = '{6'h05, 6'h05, 6'h20, 6'h05, 6'h20};
  logic [7:0] v_d [5] = '{8'h3C, 8'h00, 8'hB1, 8'h00, 8'h00};
  logic [7:0] v_r [5] = '{8'h00, 8'h3C, 8'h00, 8'h3C, 8'hB1};

  initial begin
    exp_t e2;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr_in = '0; bus1.wdata = '0;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr_in = '0; bus2.wdata = '0;

    // Reset state
    #22;
    chk("reset_busy", 32'(bus1.busy), 0);
    chk("reset_done", 32'(bus1.done), 0);
    chk("reset_strobes", 32'({bus1.READ, bus1.WRITE}), 0);
    chk("reset_mem_addr", 32'(bus1.mem_addr), 0);
    chk("reset_rdata", 32'(bus1.rdata), 0);
    chk("reset_data_released", 32'(data1), 32'(KEEP));
    chk("reset_busy_2", 32'(bus2.busy), 0);
    chk("reset_data_released_2", 32'(data2), 32'(KEEP));
    @(negedge clk);
    rst_n = 1'b1;

    // Write/read round trip
    issue(1, 1'b1, 6'h2A, 8'hA5, 8'h00, 1'b0);
    wait_done(1);
    chk("memory_written", 32'(mem1[6'h2A]), 32'h A5);
    issue(1, 1'b0, 6'h2A, 8'h00, 8'hA5, 1'b0);
    wait_done(1);

    // req during STROBE of a read is ignored
    issue(1, 1'b0, 6'h10, 8'h00, 8'h7E, 1'b0);
    for (int i = 0; i < 10 && !bus1.READ; i++) @(negedge clk);
    bus1.req = 1'b1;
    bus1.addr_in = 6'h01;
    @(negedge clk);
    bus1.req = 1'b0;
    wait_done(1);
    repeat (8) @(negedge clk);

    // Held req: back-to-back reads one IDLE cycle apart
    issue(1, 1'b0, 6'h00, 8'h00, 8'h11, 1'b1);
    bus1.addr_in = 6'h3F;
    e2.is_wr = 1'b0; e2.wd = 8'h00; e2.rd = 8'hE7; e2.cnt = edge_cnt + 5 + S1 + T1;
    sb1.push_back(e2);
    rd_model1 = 8'hE7;
    repeat (5) @(posedge clk);
    #1;
    bus1.req = 1'b0;
    wait_done(1);
    repeat (4) @(negedge clk);

    // Reset during the second STROBE cycle of a read
    issue(1, 1'b0, 6'h10, 8'h00, 8'h7E, 1'b0);
    for (int i = 0; i < 10 && !bus1.READ; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_read_low", 32'(bus1.READ), 0);
    chk("abort_write_low", 32'(bus1.WRITE), 0);
    chk("abort_busy", 32'(bus1.busy), 0);
    chk("abort_done", 32'(bus1.done), 0);
    chk("abort_mem_addr", 32'(bus1.mem_addr), 0);
    chk("abort_rdata", 32'(bus1.rdata), 0);
    chk("abort_data_released", 32'(data1), 32'(KEEP));
    sb1.delete();
    rd_model1 = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(1, 1'b0, 6'h2A, 8'h00, 8'hA5, 1'b0);
    wait_done(1);

    // Slow-timing instance: alternating writes and reads
    for (int i = 0; i < 5; i++) begin
      issue(2, v_w[i], v_a[i], v_d[i], v_r[i], 1'b0);
      wait_done(2);
    end

    repeat (6) @(negedge clk);
    chk("scoreboard_drained_1", 32'(sb1.size()), 0);
    chk("scoreboard_drained_2", 32'(sb2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the 64x8 shared-bus data memory.
- Converts single-cycle read/write requests from the core into sequenced address setup, READ/WRITE strobes and bus turnaround on the bidirectional 8-bit data bus.
- Captures read data into a holding register and signals completion to the core.
- Sits between the CPU control unit and the memory block.

Parameters:
- ADDR_W, 6, memory address width
- DATA_W, 8, data bus width
- SETUP_CYC, 1, cycles address (and write data) are stable before strobe rises; legal 1..15
- STROBE_CYC, 2, cycles READ/WRITE strobe is held high; legal 1..15

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  core request; sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr_in  input  ADDR_W  request address; sampled with req
- wdata  input  DATA_W  write data; sampled with req
- busy  output  1  high from the cycle after acceptance until return to IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  DATA_W  last captured read data
- mem_addr  output  ADDR_W  address to memory
- READ  output  1  memory read strobe
- WRITE  output  1  memory write strobe
- data  inout  DATA_W  shared memory data bus

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, READ=0, WRITE=0, mem_addr=0, rdata=0, data bus released to Z immediately. Outputs do not wait for a clock edge.
- All outputs are registered. Counter is 4 bits.
- States: IDLE, SETUP, STROBE, TAIL.
- Acceptance:
  - A request is accepted on the clock edge where state==IDLE and req==1.
  - On acceptance, latch we, addr_in and wdata, then go to SETUP.
  - req in any other state is ignored; it is not queued.
- SETUP (SETUP_CYC cycles):
  - mem_addr is driven with the latched address; READ=0 and WRITE=0.
  - Write: data is driven with the latched wdata.
  - Read: data is Z.
- STROBE (STROBE_CYC cycles):
  - Read: READ=1 and data is Z. The memory drives the bus.
  - Write: WRITE=1 and data stays driven.
  - On the edge leaving STROBE for a read, data is captured into rdata.
- TAIL (1 cycle):
  - READ=0, WRITE=0, done=1, mem_addr held.
  - Write: data is still driven, giving hold time after WRITE falls.
  - Read: data is Z.
  - Next state is IDLE.
- Latency: with acceptance at edge 0, done is high in cycle SETUP_CYC+STROBE_CYC+1. With defaults that is cycle 4, for reads and writes alike.
- Back-to-back: a request may be accepted on the edge leaving TAIL→IDLE only if req is high in IDLE. The minimum gap between operations is therefore one IDLE cycle.
- Bus discipline:
  - The master drives data only for a write in SETUP/STROBE/TAIL.
  - The master never drives data while READ=1.
  - READ and WRITE are never high simultaneously.
  - Strobes never change in the same cycle as mem_addr.
- rdata holds its value across writes and idle. It is updated only by a completed read.
- Reset during an operation:
  - The operation is aborted immediately and no done pulse occurs.
  - rdata returns to 0.
  - A write aborted after the WRITE rising edge may already have updated memory; that is acceptable.
- busy=1 in SETUP, STROBE and TAIL; busy=0 in IDLE.

Test Plan:
- Reset values: assert rst_n=0 mid-sim -> busy=0, done=0, READ=0, WRITE=0, mem_addr=0, rdata=0, data=Z without a clock edge.
- Write/read round trip: write 0xA5 to addr 0x2A, then read 0x2A -> WRITE high exactly 2 cycles after 1 setup cycle, done in cycle 4 each time, rdata=0xA5.
- req while busy: pulse req with addr 0x01 during STROBE of a read of 0x10 -> ignored, only one done pulse, rdata=mem[0x10].
- Held req back-to-back: req=1 continuously with reads of 0x00 then 0x3F -> one IDLE cycle between TAIL and the next SETUP, two done pulses 5 cycles apart.
- Reset mid-read: deassert rst_n during the second STROBE cycle -> READ falls immediately, no done, rdata=0, next request proceeds normally.
- Contention/parameter check: SETUP_CYC=3, STROBE_CYC=3, alternating reads and writes -> done in cycle 7, and an assertion confirms data is never driven by the master while READ=1.
